// File: rtl/source_lfsr_pkt.sv
// Packetised valid/ready traffic source driven by a 16-bit Fibonacci LFSR.
// Every beat and every gap length follows from SEED, so a bench can predict the stream exactly.
module source_lfsr_pkt #(
  parameter int          LEN     = 8,
  parameter int          PKT_LEN = 4,
  parameter int          DLY_W   = 3,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic           ready,
  output logic           valid,
  output logic           last,
  output logic [LEN-1:0] data,
  output logic [15:0]    pkt_cnt
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nxt;
  logic             fb;
  logic [DLY_W-1:0] gap;
  logic [DLY_W-1:0] gap_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_inc;
  logic [1:0]       mode_q;
  logic             pkt_gap_mode;

  assign fb           = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_nxt     = {lfsr[14:0], fb};
  assign gap          = lfsr_nxt[15 -: DLY_W];
  assign beat_inc     = beat_cnt + 1'b1;
  assign pkt_gap_mode = (mode == 2'd1) || (mode == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lfsr     <= SEED;
      gap_cnt  <= '0;
      beat_cnt <= '0;
      mode_q   <= 2'd0;
      valid    <= 1'b0;
      last     <= 1'b0;
      data     <= '0;
      pkt_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state  <= SEND;
            mode_q <= mode;
            valid  <= 1'b1;
            data   <= lfsr[LEN-1:0];
            last   <= (LAST_BEAT == '0);
          end
        end
        SEND: begin
          // The LFSR only moves on an accepted beat; a stalled beat holds everything.
          if (ready) begin
            lfsr <= lfsr_nxt;
            if (last) begin
              pkt_cnt  <= pkt_cnt + 16'd1;
              beat_cnt <= '0;
              mode_q   <= mode;
              if (!en) begin
                state <= IDLE;
                valid <= 1'b0;
                last  <= 1'b0;
              end else if (pkt_gap_mode && (gap != '0)) begin
                state   <= GAP;
                gap_cnt <= gap - 1'b1;
                valid   <= 1'b0;
                last    <= 1'b0;
              end else begin
                data <= lfsr_nxt[LEN-1:0];
                last <= (LAST_BEAT == '0);
              end
            end else begin
              beat_cnt <= beat_inc;
              if ((mode_q == 2'd2) && (gap != '0)) begin
                state   <= GAP;
                gap_cnt <= gap - 1'b1;
                valid   <= 1'b0;
                last    <= 1'b0;
              end else begin
                data <= lfsr_nxt[LEN-1:0];
                last <= (beat_inc == LAST_BEAT);
              end
            end
          end
        end
        GAP: begin
          // beat_cnt==0 here means the gap sits between packets, where en may stop us.
          if ((beat_cnt == '0) && !en) begin
            state <= IDLE;
          end else if (gap_cnt == '0) begin
            state <= SEND;
            valid <= 1'b1;
            data  <= lfsr[LEN-1:0];
            last  <= (beat_cnt == LAST_BEAT);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_source_lfsr_pkt.sv
// Directed bench for source_lfsr_pkt with default parameters (LEN=8, PKT_LEN=4, DLY_W=3).
// Beat values and gap lengths were worked out by hand from SEED=16'hACE1.
module tb_source_lfsr_pkt;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       ready;
  logic       valid;
  logic       last;
  logic [7:0] data;
  logic [15:0] pkt_cnt;

  int total = 0;
  int bad   = 0;

  source_lfsr_pkt dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .ready   (ready),
    .valid   (valid),
    .last    (last),
    .data    (data),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".data"},  32'(data),  32'(d));
    chk({tag, ".last"},  32'(last),  32'(l));
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s.valid%0d", tag, i), 32'(valid), 32'd0);
      chk($sformatf("%s.last%0d", tag, i),  32'(last),  32'd0);
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    mode  = 2'd0;
    ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.valid",   32'(valid),   32'd0);
    chk("rst.last",    32'(last),    32'd0);
    chk("rst.data",    32'(data),    32'd0);
    chk("rst.pkt_cnt", 32'(pkt_cnt), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    ready = 1'b0;

    // Back-to-back stream, two full packets
    do_reset();
    en = 1'b1; ready = 1'b1;
    expect_beat("b2b.b1", 8'hE1, 1'b0);
    expect_beat("b2b.b2", 8'hC3, 1'b0);
    expect_beat("b2b.b3", 8'h87, 1'b0);
    expect_beat("b2b.b4", 8'h0F, 1'b1);
    chk("b2b.cnt_b4", 32'(pkt_cnt), 32'd0);
    expect_beat("b2b.b5", 8'h1E, 1'b0);
    chk("b2b.cnt_b5", 32'(pkt_cnt), 32'd1);
    expect_beat("b2b.b6", 8'h3C, 1'b0);
    expect_beat("b2b.b7", 8'h79, 1'b0);
    expect_beat("b2b.b8", 8'hF2, 1'b1);
    @(negedge clk);
    chk("b2b.cnt_b9", 32'(pkt_cnt), 32'd2);

    // Gap between every beat: gaps 2 then 5
    do_reset();
    mode = 2'd2; en = 1'b1; ready = 1'b1;
    expect_beat("m2.b1", 8'hE1, 1'b0);
    expect_idle("m2.gap2", 2);
    expect_beat("m2.b2", 8'hC3, 1'b0);
    expect_idle("m2.gap5", 5);
    expect_beat("m2.b3", 8'h87, 1'b0);

    // ready ignored while idle, then backpressure on the first beat
    do_reset();
    ready = 1'b1;
    expect_idle("idle_rdy", 3);
    ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) expect_beat($sformatf("bp.hold%0d", i), 8'hE1, 1'b0);
    ready = 1'b1;
    expect_beat("bp.next", 8'hC3, 1'b0);
    expect_beat("bp.next2", 8'h87, 1'b0);

    // en dropped after beat 2: packet completes, then idle
    do_reset();
    en = 1'b1; ready = 1'b1;
    expect_beat("endrop.b1", 8'hE1, 1'b0);
    expect_beat("endrop.b2", 8'hC3, 1'b0);
    en = 1'b0;
    expect_beat("endrop.b3", 8'h87, 1'b0);
    expect_beat("endrop.b4", 8'h0F, 1'b1);
    expect_idle("endrop.idle", 5);
    chk("endrop.cnt", 32'(pkt_cnt), 32'd1);

    // mode 0 -> 1 mid-packet: no inner gap, 6-cycle gap after the packet
    do_reset();
    en = 1'b1; ready = 1'b1;
    expect_beat("m01.b1", 8'hE1, 1'b0);
    mode = 2'd1;
    expect_beat("m01.b2", 8'hC3, 1'b0);
    expect_beat("m01.b3", 8'h87, 1'b0);
    expect_beat("m01.b4", 8'h0F, 1'b1);
    expect_idle("m01.gap6", 6);
    expect_beat("m01.b5", 8'h1E, 1'b0);
    expect_beat("m01.b6", 8'h3C, 1'b0);

    // Asynchronous reset mid-packet
    do_reset();
    en = 1'b1; ready = 1'b1;
    expect_beat("arst.b1", 8'hE1, 1'b0);
    expect_beat("arst.b2", 8'hC3, 1'b0);
    expect_beat("arst.b3", 8'h87, 1'b0);
    expect_beat("arst.b4", 8'h0F, 1'b1);
    expect_beat("arst.b5", 8'h1E, 1'b0);
    chk("arst.cnt_pre", 32'(pkt_cnt), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst.valid", 32'(valid),   32'd0);
    chk("arst.last",  32'(last),    32'd0);
    chk("arst.data",  32'(data),    32'd0);
    chk("arst.cnt",   32'(pkt_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    expect_beat("arst.rb1", 8'hE1, 1'b0);
    chk("arst.cnt_post", 32'(pkt_cnt), 32'd0);
    expect_beat("arst.rb2", 8'hC3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/source_lfsr_pkt.md
Name: source_lfsr_pkt

Overview:
Parametrised, synthesizable successor to the random valid/data source. It generates packetised valid/ready traffic with a deterministic 16-bit LFSR instead of $random. Benches can therefore predict every beat. It adds a packet length, a `last` flag on the final beat, selectable gap modes, an enable and a completed-packet counter. It drives sink/sum blocks in unit benches and on FPGA bring-up.

Parameters:
LEN, 8, data width in bits; legal range 1..16.
PKT_LEN, 4, beats per packet; must be >=1.
DLY_W, 3, gap field width; gaps are 0..2^DLY_W-1 cycles; legal range 1..8.
SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  start/continue generating packets
mode  in  2  0 = back-to-back, 1 = gap between packets, 2 = gap between every beat, 3 = same as 0
ready  in  1  sink accepts the current beat
valid  out  1  beat available
last  out  1  final beat of the packet; qualified by valid
data  out  LEN  beat payload
pkt_cnt  out  16  number of completed packets; wraps at 16'hFFFF -> 0

Behaviour:
- Reset: `rst` low clears asynchronously. valid=0, last=0, data=0, pkt_cnt=0, lfsr=SEED, beat counter=0, state=IDLE.
- LFSR: Fibonacci shift-left.
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - It advances exactly once per accepted beat (valid && ready), and at no other time.
- Beat content: data = lfsr[LEN-1:0], loaded whenever a beat is presented.
  - last = (beat counter == PKT_LEN-1).
- Gap length = the top DLY_W bits of the post-advance LFSR, i.e. next[15 -: DLY_W].
- State IDLE: valid=0.
  - A clock edge with en=1 moves to SEND.
  - valid rises one cycle after en is first sampled high.
  - The mode is latched at this edge.
- State SEND: valid=1. data and last are held stable until ready.
  - ready=0: hold every output. This is AXI-stream stability.
  - ready=1, not last, latched mode 2:
    - If the gap is 0, present the next beat on the following cycle.
    - Otherwise go to GAP.
  - ready=1, not last, any other mode: present the next beat back-to-back.
  - ready=1, last:
    - pkt_cnt increments.
    - The beat counter clears.
    - Re-latch mode.
    - If en=0, go to IDLE.
    - Else if the new mode is 1 or 2 and the gap is nonzero, go to GAP.
    - Else present beat 0 of the next packet in the following cycle.
- State GAP: valid=0 for exactly the gap number of cycles, then SEND with the next beat.
  - A gap of N means N cycles with valid low between the two accepted beats.
  - en=0 during a gap between packets ends in IDLE instead.
- en=0 mid-packet: the current packet always completes, then the block goes to IDLE. A truncated packet is never emitted.
- mode changes take effect only at packet boundaries.
- ready while valid=0 is ignored and has no side effects.
- Reset asserted mid-packet aborts immediately. After release, the first beat is again SEED[LEN-1:0].
- last is never high while valid=0.

Test Plan:
- Reset, en=1, mode=0, ready=1 constantly, LEN=8, PKT_LEN=4:
  - data sequence starts 8'hE1, 8'hC3, ...
  - valid stays high with no gaps.
  - last is high on beats 4, 8, ...
  - pkt_cnt=1 after beat 4.
- mode=2, DLY_W=3, ready=1:
  - Beat 8'hE1 is accepted; the LFSR becomes 16'h59C3 and the gap is 3'b010.
  - Exactly 2 cycles with valid=0 follow.
  - Then 8'hC3 is presented.
- Backpressure: ready=0 for 5 cycles while valid=1.
  - data, last and valid are unchanged.
  - The LFSR does not advance.
  - The next accepted data equals the held value.
- en dropped after beat 2 of a 4-beat packet:
  - Beats 3 and 4 are still delivered, with last on beat 4.
  - Then valid=0 indefinitely.
  - pkt_cnt=1.
- mode changed 0 -> 1 mid-packet:
  - No gap appears inside the current packet.
  - A gap of LFSR-derived length appears after its last beat.
- rst pulsed low mid-packet, asynchronously between clock edges:
  - Outputs clear immediately.
  - After release with en=1, the first beat is 8'hE1 and pkt_cnt=0.
